// File: rtl/conv_3x3_4ch_win_sched.sv
// Streaming 3x3 window scheduler: two line buffers build interior windows from a raster
// pixel stream, feed the 4-channel convolution core and register results onto valid/ready.

module conv_3x3_4ch_lane #(
    parameter int CH    = 0,
    parameter int VEC_W = 16
) (
    input  logic [71:0]      pixels_in,
    output logic [VEC_W-1:0] sum
);
    // Tap k of channel CH carries weight k+2+CH; worst case 81*255 fits in 16 bits.
    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++)
            sum = sum + VEC_W'(pixels_in[8*k +: 8]) * VEC_W'(k + 2 + CH);
    end
endmodule

module conv_3x3_4ch_vl1 #(
    parameter int NUM_LANES = 4,
    parameter int VEC_W     = 16
) (
    input  logic [71:0]                pixels_in,
    output logic [NUM_LANES*VEC_W-1:0] result
);
    logic [NUM_LANES-1:0][VEC_W-1:0] lane_sum;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        conv_3x3_4ch_lane #(.CH(g), .VEC_W(VEC_W)) u_lane (
            .pixels_in (pixels_in),
            .sum       (lane_sum[g])
        );
    end

    assign result = lane_sum;
endmodule

module conv_3x3_4ch_win_sched #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [63:0] res_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [71:0] win_dbg,
    output logic        frame_done,
    output logic        busy
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];

    // [r][c] with r=0 the oldest row, c=0 the leftmost column; flattens to tap 3r+c.
    logic [2:0][2:0][7:0] win, win_nxt;
    logic [2:0][7:0]      col_new;
    logic                 win_vld;
    logic                 s2_free, accept, emit;
    logic [63:0]          core_res;

    assign s2_free   = !res_valid || res_ready;
    assign pix_ready = !win_vld || s2_free;
    assign accept    = pix_valid && pix_ready;
    assign emit      = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign busy      = win_vld || res_valid || (col != '0) || (row != '0);

    always_comb begin
        col_new = {pix_in, lb0[col], lb1[col]};
        win_nxt = '0;
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win[r][1];
            win_nxt[r][1] = win[r][2];
            win_nxt[r][2] = col_new[r];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            win        <= '0;
            win_dbg    <= '0;
            win_vld    <= 1'b0;
            res_out    <= '0;
            res_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && (col == COL_LAST) && (row == ROW_LAST);
            if (accept) begin
                win <= win_nxt;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            // A new window may load while the previous one advances to the output stage.
            if (emit)
                win_dbg <= win_nxt;
            if (emit)
                win_vld <= 1'b1;
            else if (s2_free)
                win_vld <= 1'b0;
            if (win_vld && s2_free) begin
                res_out   <= core_res;
                res_valid <= 1'b1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    conv_3x3_4ch_vl1 u_core (
        .pixels_in (win_dbg),
        .result    (core_res)
    );
endmodule

// File: tb/tb_conv_3x3_4ch_win_sched.sv
// Directed bench for the window scheduler: a 4x4 instance for bring-up, stall and reset
// scenarios, and an 8x8 instance for constant frames and randomly stalled back-to-back frames.

module tb_conv_3x3_4ch_win_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst4, pix_valid4, pix_ready4, res_valid4, res_ready4, frame_done4, busy4;
    logic [7:0]  pix_in4;
    logic [63:0] res_out4;
    logic [71:0] win_dbg4;
    logic        rst8, pix_valid8, pix_ready8, res_valid8, res_ready8, frame_done8, busy8;
    logic [7:0]  pix_in8;
    logic [63:0] res_out8;
    logic [71:0] win_dbg8;

    conv_3x3_4ch_win_sched #(.IMG_W(4), .IMG_H(4)) d4 (
        .clk(clk), .rst(rst4), .pix_in(pix_in4), .pix_valid(pix_valid4), .pix_ready(pix_ready4),
        .res_out(res_out4), .res_valid(res_valid4), .res_ready(res_ready4), .win_dbg(win_dbg4),
        .frame_done(frame_done4), .busy(busy4)
    );

    conv_3x3_4ch_win_sched #(.IMG_W(8), .IMG_H(8)) d8 (
        .clk(clk), .rst(rst8), .pix_in(pix_in8), .pix_valid(pix_valid8), .pix_ready(pix_ready8),
        .res_out(res_out8), .res_valid(res_valid8), .res_ready(res_ready8), .win_dbg(win_dbg8),
        .frame_done(frame_done8), .busy(busy8)
    );

    logic [63:0] q4[$];
    logic [63:0] q8[$];
    int          fd4 = 0;
    int          fd8 = 0;
    logic [7:0]  pix8 [192];
    int          exp4 [4] = '{348, 402, 564, 618};

    // Inputs only change at posedge+1, so the negedge view predicts the next edge's handshake.
    always @(negedge clk) begin
        if (res_valid4 && res_ready4) q4.push_back(res_out4);
        if (res_valid8 && res_ready8) q8.push_back(res_out8);
        if (frame_done4) fd4++;
        if (frame_done8) fd8++;
    end

    task automatic drive4(input int n, input bit rnd);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < n && cyc < 4000) begin
            pix_in4    = 8'(i);
            pix_valid4 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = pix_valid4 && pix_ready4;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        pix_valid4 = 1'b0;
        checks++;
        if (i != n) begin errors++; $display("FAIL drive4_timeout accepted=%0d required=%0d", i, n); end
    endtask

    task automatic drive8(input int base, input int n, input bit rnd);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < n && cyc < 8000) begin
            pix_in8    = pix8[base + i];
            pix_valid8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = pix_valid8 && pix_ready8;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        pix_valid8 = 1'b0;
        checks++;
        if (i != n) begin errors++; $display("FAIL drive8_timeout accepted=%0d required=%0d", i, n); end
    endtask

    function automatic logic [63:0] ref8(input int f, input int r, input int c);
        logic [63:0] v = '0;
        int s;
        for (int ch = 0; ch < 4; ch++) begin
            s = 0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    s += int'(pix8[f*64 + (r+dr)*8 + c + dc]) * (3*dr + dc + 2 + ch);
            v[16*ch +: 16] = 16'(s);
        end
        return v;
    endfunction

    task automatic check_q4(input int base, input string tag);
        checks++;
        if (q4.size() != base + 4) begin
            errors++; $display("FAIL %s_count got=%0d required=4", tag, q4.size() - base);
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (q4[base+j][15:0] !== 16'(exp4[j])) begin
                    errors++; $display("FAIL %s_ch0[%0d] got=%0d required=%0d", tag, j, q4[base+j][15:0], exp4[j]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst8 = 1'b1;
        pix_valid4 = 1'b0; pix_valid8 = 1'b0; pix_in4 = '0; pix_in8 = '0;
        res_ready4 = 1'b1; res_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst4 = 1'b0; rst8 = 1'b0;
        @(negedge clk);
        checks++;
        if ({res_valid4, frame_done4, busy4, pix_ready4} !== 4'b0001 || res_out4 !== '0 || win_dbg4 !== '0) begin
            errors++; $display("FAIL reset4 v/fd/busy/rdy=%b res=%h win=%h required 0001/0/0",
                               {res_valid4, frame_done4, busy4, pix_ready4}, res_out4, win_dbg4);
        end
        checks++;
        if ({res_valid8, frame_done8, busy8, pix_ready8} !== 4'b0001 || res_out8 !== '0 || win_dbg8 !== '0) begin
            errors++; $display("FAIL reset8 v/fd/busy/rdy=%b res=%h win=%h required 0001/0/0",
                               {res_valid8, frame_done8, busy8, pix_ready8}, res_out8, win_dbg8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bringup();
        int base = q4.size();
        int f0 = fd4;
        drive4(16, 1'b0);
        checks++;
        if (frame_done4 !== 1'b1) begin errors++; $display("FAIL bringup_fd_pulse got=%b required=1", frame_done4); end
        @(posedge clk); #1;
        checks++;
        if (frame_done4 !== 1'b0) begin errors++; $display("FAIL bringup_fd_clear got=%b required=0", frame_done4); end
        repeat (8) @(posedge clk); #1;
        check_q4(base, "bringup");
        checks++;
        if (q4.size() > base && q4[base][63:48] !== 16'd483) begin
            errors++; $display("FAIL bringup_ch3 got=%0d required=483", q4[base][63:48]);
        end
        checks++;
        if (fd4 - f0 != 1) begin errors++; $display("FAIL bringup_fd_count got=%0d required=1", fd4 - f0); end
    endtask

    task automatic test_backpressure();
        int base = q4.size();
        res_ready4 = 1'b0;
        fork
            drive4(16, 1'b0);
            begin
                int c = 0;
                @(negedge clk);
                while (!res_valid4 && c < 200) begin @(negedge clk); c++; end
                checks++;
                if (res_valid4 !== 1'b1) begin errors++; $display("FAIL bp_wait res_valid=%b required=1", res_valid4); end
                for (int j = 0; j < 5; j++) begin
                    if (j > 0) @(negedge clk);
                    checks++;
                    if (res_out4[15:0] !== 16'd348) begin
                        errors++; $display("FAIL bp_hold[%0d] ch0=%0d required=348", j, res_out4[15:0]);
                    end
                    checks++;
                    if (pix_ready4 !== 1'b0) begin
                        errors++; $display("FAIL bp_pix_ready[%0d] got=%b required=0", j, pix_ready4);
                    end
                end
                @(posedge clk); #1 res_ready4 = 1'b1;
            end
        join
        repeat (10) @(posedge clk); #1;
        check_q4(base, "bp");
    endtask

    task automatic test_reset_mid_frame();
        int base;
        res_ready4 = 1'b1;
        drive4(10, 1'b0);
        #2 rst4 = 1'b1;
        #1;
        checks++;
        if ({res_valid4, frame_done4, busy4} !== 3'b000 || res_out4 !== '0 || win_dbg4 !== '0) begin
            errors++; $display("FAIL midrst v/fd/busy=%b res=%h win=%h required 000/0/0",
                               {res_valid4, frame_done4, busy4}, res_out4, win_dbg4);
        end
        @(posedge clk); #3 rst4 = 1'b0;
        @(posedge clk); #1;
        base = q4.size();
        drive4(16, 1'b0);
        repeat (8) @(posedge clk); #1;
        check_q4(base, "midrst");
    endtask

    task automatic test_constant();
        int base;
        res_ready8 = 1'b1;
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 64; i++) pix8[i] = (v == 0) ? 8'd1 : 8'd255;
            base = q8.size();
            drive8(0, 64, 1'b0);
            repeat (8) @(posedge clk); #1;
            checks++;
            if (q8.size() != base + 36) begin
                errors++; $display("FAIL const%0d_count got=%0d required=36", v, q8.size() - base);
            end else begin
                for (int j = 0; j < 36; j++) begin
                    checks++;
                    if (v == 0 && q8[base+j] !== {16'd81, 16'd72, 16'd63, 16'd54}) begin
                        errors++; $display("FAIL const1[%0d] got=%h required=%h", j, q8[base+j], {16'd81, 16'd72, 16'd63, 16'd54});
                    end
                    if (v == 1 && (q8[base+j][63:48] !== 16'd20655 || q8[base+j][15:0] !== 16'd13770)) begin
                        errors++; $display("FAIL const255[%0d] ch3=%0d ch0=%0d required 20655/13770", j, q8[base+j][63:48], q8[base+j][15:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_random_stalls();
        int base = q8.size();
        int f0 = fd8;
        int n = 0;
        bit done = 1'b0;
        for (int i = 0; i < 192; i++) pix8[i] = 8'($urandom_range(0, 255));
        fork
            begin drive8(0, 192, 1'b1); done = 1'b1; end
            while (!done) begin
                @(posedge clk); #1;
                if (!done) res_ready8 = 1'($urandom_range(0, 1));
            end
        join
        res_ready8 = 1'b1;
        repeat (20) @(posedge clk); #1;
        checks++;
        if (q8.size() != base + 108) begin
            errors++; $display("FAIL rand_count got=%0d required=108", q8.size() - base);
        end else begin
            for (int f = 0; f < 3; f++)
                for (int r = 0; r < 6; r++)
                    for (int c = 0; c < 6; c++) begin
                        checks++;
                        if (q8[base+n] !== ref8(f, r, c)) begin
                            errors++; $display("FAIL rand[%0d] got=%h required=%h", n, q8[base+n], ref8(f, r, c));
                        end
                        n++;
                    end
        end
        checks++;
        if (fd8 - f0 != 3) begin errors++; $display("FAIL rand_frame_done got=%0d required=3", fd8 - f0); end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_backpressure();
        test_reset_mid_frame();
        test_constant();
        test_random_stalls();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_3x3_4ch_win_sched.md
Name: conv_3x3_4ch_win_sched

Overview:
Streaming window scheduler for the 3x3, 4-channel convolution core. Accepts a raster-order 8-bit pixel stream and builds 3x3 windows from two line buffers. Each complete window goes to an internal instance of conv_3x3_4ch_vl1, and the 64-bit packed result is registered onto a valid/ready output. Only fully interior windows are produced (no padding), so a frame yields (IMG_H-2)*(IMG_W-2) results.

Parameters:
IMG_W, 8, pixels per row (>=3)
IMG_H, 8, rows per frame (>=3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
pix_in  in  8  input pixel
pix_valid  in  1  pix_in valid
pix_ready  out  1  scheduler can accept pix_in this cycle
res_out  out  64  packed result: ch0 [15:0], ch1 [31:16], ch2 [47:32], ch3 [63:48]
res_valid  out  1  res_out valid
res_ready  in  1  downstream accepts res_out
win_dbg  out  72  registered window presented to the core (debug/verification)
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted
busy  out  1  high when win_vld or res_valid is set, or any pixel of the current frame is accepted

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - col, row = 0.
  - win_vld, res_valid, frame_done = 0.
  - res_out, win_dbg, 3x3 shift window = 0.
  - Line-buffer RAM contents are don't-care and are not reset.
- Accept condition: accept = pix_valid && pix_ready.
- Backpressure:
  - s2_free = !res_valid || res_ready.
  - pix_ready = !win_vld || s2_free (combinational).
- Stage 0, on accept:
  - New column = {lb1[col], lb0[col], pix_in}, ordered top to bottom.
  - lb1[col] <= lb0[col]; lb0[col] <= pix_in.
  - The shift window moves left one column, and the new column enters on the right.
- Stage 0 counters:
  - col increments; at col==IMG_W-1 it wraps to 0 and row increments.
  - At row==IMG_H-1 && col==IMG_W-1, both counters return to 0 and frame_done pulses next cycle.
- Window emit:
  - If accept && row>=2 && col>=2, the updated window is loaded into win_dbg and win_vld<=1 at the next edge.
  - Tap k = 3*r + c, with r=0 the oldest row and c=0 the leftmost column.
  - Tap k sits at win_dbg[8k+7:8k]; tap 8 = pix_in.
  - Windows straddling a row wrap (col<2) or with row<2 are never emitted.
- Stage 1:
  - win_dbg feeds the conv_3x3_4ch_vl1 pixels_in combinationally.
  - Channel c, tap k weight = k+2+c.
  - Sums are 16-bit; the maximum is 81*255 = 20655, so there is no overflow.
- Stage 2:
  - When win_vld && s2_free: res_out <= core output, res_valid <= 1.
  - win_vld clears unless a new window loads the same cycle.
  - When res_valid && res_ready with no new load, res_valid <= 0.
  - res_out holds while res_valid && !res_ready.
- Latency: the emitting pixel is accepted at edge N, win_dbg is valid after N, and res_out is valid after N+1 when there is no stall.
- Throughput: one pixel per cycle when res_ready is held high.
- Simultaneous events:
  - Load of a new window and advance of the old window to stage 2 in the same cycle is legal (pipeline flow).
  - Result handshake and a new result in the same cycle keeps res_valid=1 with the new data.
- Reset mid-frame: all state returns to reset values immediately, the partial frame is discarded, and the next accepted pixel is row 0, col 0.
- Frame boundary: the first pixel of the next frame may be accepted in the cycle frame_done is high.

Test Plan:
- Bring-up:
  - Stimulus: IMG_W=IMG_H=4; pixels 0..15 raster order; pix_valid=1; res_ready=1.
  - Response: exactly 4 results with ch0 = 348, 402, 564, 618.
  - Response: ch3 of the first result = 0*5+1*6+2*7+4*8+5*9+6*10+8*11+9*12+10*13 = 483.
  - Response: frame_done pulses once, the cycle after pixel 15 is accepted.
- Constant input:
  - Stimulus: 8x8 frame of all 1s.
  - Response: 36 results, each res_out = {81,72,63,54}.
  - Response: all 255s gives ch3 = 20655 and ch0 = 13770.
- Backpressure:
  - Stimulus: bring-up frame with res_ready low for 5 cycles after the first res_valid.
  - Response: res_out stays stable at ch0=348 and pix_ready falls once win_vld is set.
  - Response: no result is lost or duplicated, and the order is unchanged.
- Random stalls:
  - Stimulus: random pix_valid and random res_ready over 3 back-to-back 8x8 frames.
  - Response: results match a reference model bit-exactly, 108 results in total, 3 frame_done pulses.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously after pixel 9 of the 4x4 frame, then send a full frame.
  - Response: all outputs are 0 immediately, then the new frame gives results 348, 402, 564, 618.
